msf_frame_decoder: RTL
======================

# msf_frame_decoder

Assembles one MSF time-code frame from the per-second A/B bit pairs produced by the pulse-width demodulator. At each minute marker it validates the completed frame (bit count, 52–59 marker pattern, time parity, BCD range) and, if valid, emits a single-cycle load with BCD hour/minute values and seconds = 00. It is the producer side of the clock digit chain's load interface: its outputs connect directly to that chain's load strobe and six load-value buses.

## Interface

Parameters: none.

- `clk_i`  in  1  system clock
- `rst_ni`  in  1  asynchronous, active-low reset
- `minute_i`  in  1  one-cycle pulse: minute marker (second 0) detected by demodulator
- `bit_valid_i`  in  1  one-cycle pulse: bits for seconds 1..59 available
- `bit_a_i`  in  1  A bit for current second, valid with `bit_valid_i`
- `bit_b_i`  in  1  B bit for current second, valid with `bit_valid_i`
- `load_o`  out  1  one-cycle pulse: load time into digit chain
- `hour_h_o`  out  2  hours tens, BCD 0..2
- `hour_l_o`  out  4  hours units, BCD 0..9
- `minute_h_o`  out  3  minutes tens, BCD 0..5
- `minute_l_o`  out  4  minutes units, BCD 0..9
- `second_h_o`  out  3  always 0
- `second_l_o`  out  4  always 0
- `locked_o`  out  1  high while the last completed frame was valid
- `frame_err_o`  out  1  one-cycle pulse: frame rejected

## Operation

- `sec_q`: 6-bit second index. Holds 0 after reset and after any error: no frame in progress, so bits are ignored until a marker arrives.
- `minute_i` sets `sec_q` = 1 after evaluating the frame just ended; the next `bit_valid_i` is second 1.
- Each accepted `bit_valid_i` stores bits by index and increments `sec_q`:
  - A39–40: hour tens (20, 10); A41–44: hour units (8, 4, 2, 1).
  - A45–47: minute tens (40, 20, 10); A48–51: minute units (8, 4, 2, 1).
  - A52–59: marker field; B57: time parity.
  - All other bits are discarded.
- `bit_valid_i` while `sec_q` = 60 (a 60th data bit) is an overrun: error, set `sec_q` = 0.
- Frame valid at `minute_i` only if all of the following hold:
  - `sec_q` = 60, i.e. exactly 59 bits were received.
  - A52..A59 = 0,1,1,1,1,1,1,0.
  - Ones count of A39..A51 plus B57 is odd.
  - Hour tens ≤ 2, hour units ≤ 9, hour ≤ 23.
  - Minute tens ≤ 5, minute units ≤ 9.
- Valid frame:
  - Register the hour/minute outputs.
  - Pulse `load_o`.
  - Set `locked_o` = 1.
- Invalid frame:
  - Pulse `frame_err_o`.
  - Clear `locked_o`.
  - Value outputs are left unchanged.
- First `minute_i` after reset or after an overrun finds `sec_q` = 0. It is treated as a frame start only: no load, no error.
- A frame cut short (`minute_i` with `sec_q` ≠ 60 and ≠ 0) is an error.
- Decoded time is the time at the minute marker ending the frame, so load happens on that marker with seconds = 00.

## Timing

- Reset values: `load_o`, `frame_err_o`, `locked_o` = 0; all value outputs = 0; `sec_q` = 0; bit stores = 0.
- Latency: `load_o` / `frame_err_o` assert one cycle after `minute_i` is sampled. Value outputs update in the same cycle `load_o` asserts and hold until the next valid load.
- Output pulses last exactly one cycle.
- `minute_i` and `bit_valid_i` in the same cycle: `minute_i` wins and the bit is dropped.
- Back-to-back pulses on consecutive cycles are legal and each is processed.
- Overrun error pulses `frame_err_o` one cycle after the offending `bit_valid_i`.
- Reset assertion mid-frame: immediate return to reset state. Deassertion is synchronised externally.

## Test plan

- **Nominal frame.** Send marker, then 59 bits encoding 14:37: A39–44 = 010100, A45–51 = 0110111, A52–59 = 01111110, B57 = 0. Then send marker. -> One cycle later: `load_o` = 1, hour = 1/4, minute = 3/7, seconds = 0/0, `locked_o` = 1.
- **Parity error.** Same frame with B57 = 1. -> `frame_err_o` pulses, `load_o` stays 0, `locked_o` = 0, outputs still hold the previous 14:37.
- **Short frame.** Marker, 58 bits, marker. -> `frame_err_o` pulses. The following full 59-bit frame loads normally.
- **Overrun.** Marker, 60 bits. -> `frame_err_o` pulses one cycle after the 60th bit. The next marker produces no load and no error; the frame after it loads.
- **BCD range.** Hour 24 (A39–44 = 100100, parity corrected) or minute tens 6. -> `frame_err_o` pulses, no load.
- **Collision and reset.** `minute_i` and `bit_valid_i` asserted in the same cycle -> bit ignored, next frame counts from 1. Reset asserted at second 30 -> all outputs 0 immediately, first marker afterwards gives no pulse.

Source files
------------

// File: rtl/msf_frame_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | msf_frame_decoder: assembles MSF A/B bits, validates at marker, loads    |
// | BCD hh:mm:00 into the digit chain.                        Revision: 1.0  |
// +--------------------------------------------------------------------------+
module msf_frame_decoder (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       minute_i,
  input  logic       bit_valid_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  output logic       load_o,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic [2:0] second_h_o,
  output logic [3:0] second_l_o,
  output logic       locked_o,
  output logic       frame_err_o
);

  localparam logic [5:0] C_SEC_IDLE  = 6'd0;
  localparam logic [5:0] C_SEC_FIRST = 6'd1;
  localparam logic [5:0] C_SEC_FULL  = 6'd60;
  localparam logic [5:0] C_SEC_B57   = 6'd57;
  localparam int         C_A_BASE    = 39;
  localparam int         C_A_BITS    = 21;
  localparam logic [7:0] C_MARKER    = 8'b0111_1110;

  logic [5:0]          sec_q, sec_d;
  logic [C_A_BITS-1:0] a_q, a_d;
  logic                b57_q, b57_d;
  logic                load_q, load_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;
  logic [1:0]          hour_h_q, hour_h_d;
  logic [3:0]          hour_l_q, hour_l_d;
  logic [2:0]          min_h_q, min_h_d;
  logic [3:0]          min_l_q, min_l_d;

  // a_q[i] holds A bit of second 39+i, so A39 is the MSB of the hour tens.
  logic [1:0] w_ht;
  logic [3:0] w_hu;
  logic [2:0] w_mt;
  logic [3:0] w_mu;
  logic       w_hour_ok;
  logic       w_min_ok;
  logic       w_marker_ok;
  logic       w_parity_ok;
  logic       w_frame_ok;

  assign w_ht        = {a_q[0], a_q[1]};
  assign w_hu        = {a_q[2], a_q[3], a_q[4], a_q[5]};
  assign w_mt        = {a_q[6], a_q[7], a_q[8]};
  assign w_mu        = {a_q[9], a_q[10], a_q[11], a_q[12]};
  assign w_hour_ok   = (w_ht <= 2'd2) && (w_hu <= 4'd9) && !((w_ht == 2'd2) && (w_hu > 4'd3));
  assign w_min_ok    = (w_mt <= 3'd5) && (w_mu <= 4'd9);
  assign w_marker_ok = (a_q[20:13] == C_MARKER);
  assign w_parity_ok = ^{a_q[12:0], b57_q};
  assign w_frame_ok  = (sec_q == C_SEC_FULL) && w_marker_ok && w_parity_ok && w_hour_ok && w_min_ok;

  always_comb begin
    sec_d    = sec_q;
    a_d      = a_q;
    b57_d    = b57_q;
    load_d   = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    hour_h_d = hour_h_q;
    hour_l_d = hour_l_q;
    min_h_d  = min_h_q;
    min_l_d  = min_l_q;

    // A marker always wins over a coincident data bit.
    if (minute_i) begin
      sec_d = C_SEC_FIRST;
      if (sec_q != C_SEC_IDLE) begin
        if (w_frame_ok) begin
          load_d   = 1'b1;
          locked_d = 1'b1;
          hour_h_d = w_ht;
          hour_l_d = w_hu;
          min_h_d  = w_mt;
          min_l_d  = w_mu;
        end else begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end
      end
    end else if (bit_valid_i && (sec_q != C_SEC_IDLE)) begin
      if (sec_q == C_SEC_FULL) begin
        err_d    = 1'b1;
        locked_d = 1'b0;
        sec_d    = C_SEC_IDLE;
      end else begin
        for (int i = 0; i < C_A_BITS; i++) begin
          if (sec_q == 6'(C_A_BASE + i)) begin
            a_d[i] = bit_a_i;
          end
        end
        if (sec_q == C_SEC_B57) begin
          b57_d = bit_b_i;
        end
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sec_q    <= C_SEC_IDLE;
      a_q      <= '0;
      b57_q    <= 1'b0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
      hour_h_q <= '0;
      hour_l_q <= '0;
      min_h_q  <= '0;
      min_l_q  <= '0;
    end else begin
      sec_q    <= sec_d;
      a_q      <= a_d;
      b57_q    <= b57_d;
      load_q   <= load_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      hour_h_q <= hour_h_d;
      hour_l_q <= hour_l_d;
      min_h_q  <= min_h_d;
      min_l_q  <= min_l_d;
    end
  end

  assign load_o      = load_q;
  assign frame_err_o = err_q;
  assign locked_o    = locked_q;
  assign hour_h_o    = hour_h_q;
  assign hour_l_o    = hour_l_q;
  assign minute_h_o  = min_h_q;
  assign minute_l_o  = min_l_q;
  assign second_h_o  = 3'd0;
  assign second_l_o  = 4'd0;

endmodule
`default_nettype wire
